led_frame_scheduler: RTL and testbench

- Top-level sequencer for the WS2812B LED-matrix datapath.
- Per frame, walks pixel index 0..NUM_PIXELS-1; for each pixel, pulses the shift-register load strobe and the driver transmit strobe, then waits for the driver's per-pixel completion.
- Between frames, inserts the WS2812B latch/reset gap.
- Every FRAME_HOLD frames, requests one game-of-life generation update over a req/ack handshake.
- Replaces the free-running pixel/frame counting previously done in the top level.

---
 rtl/led_frame_scheduler_pkg.sv | 14 +
 rtl/led_frame_scheduler_if.sv | 36 +++
 rtl/led_frame_scheduler_cycle_timer.sv | 24 ++
 rtl/led_frame_scheduler.sv | 109 ++++++++++
 tb/tb_led_frame_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_frame_scheduler_pkg.sv
// led_pkg: scheduler state encoding and WS2812B constants shared by the LED datapath.
package led_pkg;

    typedef enum logic [2:0] {IDLE, LATCH, CALC, LOAD, XMIT, WAIT} sched_state_t;

    localparam int WS_COLOR_BITS        = 24;
    localparam int DEFAULT_LATCH_CYCLES = 3600;

    // Index width that stays legal for a single-element range.
    function automatic int pix_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// led_frame_scheduler_if: scheduler <-> pixel datapath/driver/life-engine bus.
// With LED_FRAME_DEBUG_EN defined the bus also carries frame_toggle and proto_err.
interface led_frame_scheduler_if #(
    parameter int PIX_W = 6
);
    logic             run;
    logic             pixel_done;
    logic             calc_ack;
    logic             load_sreg;
    logic             transmit_pixel;
    logic [PIX_W-1:0] pixel_idx;
    logic [4:0]       frame_cnt;
    logic             calc_req;
`ifdef LED_FRAME_DEBUG_EN
    logic             frame_toggle;
    logic             proto_err;

    modport master (
        input  run, pixel_done, calc_ack,
        output load_sreg, transmit_pixel, pixel_idx, frame_cnt, calc_req, frame_toggle, proto_err
    );
    modport slave (
        output run, pixel_done, calc_ack,
        input  load_sreg, transmit_pixel, pixel_idx, frame_cnt, calc_req, frame_toggle, proto_err
    );
`else
    modport master (
        input  run, pixel_done, calc_ack,
        output load_sreg, transmit_pixel, pixel_idx, frame_cnt, calc_req
    );
    modport slave (
        output run, pixel_done, calc_ack,
        input  load_sreg, transmit_pixel, pixel_idx, frame_cnt, calc_req
    );
`endif
endinterface

// File: rtl/led_frame_scheduler_cycle_timer.sv
// cycle_timer: loadable down-counter; done_o flags the last of CYCLES enabled clocks and holds there.
module cycle_timer
    import led_pkg::*;
#(
    parameter int CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic en_i,
    output logic done_o
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = start_i ? W'(CYCLES - 1) : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: walks pixels per frame, inserts the WS2812B latch gap, paces life generations.
// Optional LED_FRAME_DEBUG_EN adds frame_toggle and sticky proto_err outputs.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int NUM_PIXELS   = 64,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter int FRAME_HOLD   = 8
) (
    input logic clk,
    input logic rst_n,
    led_frame_scheduler_if.master bus
);
    localparam int PIX_W  = pix_w(NUM_PIXELS);
    localparam int HOLD_W = pix_w(FRAME_HOLD);

    sched_state_t      state_q, state_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [4:0]        frame_q, frame_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              first_q, first_d;
    logic              load_q, xmit_q, req_q;
    logic              gap_done, gap_start, gap_exit, pix_last, hold_last;

    assign gap_start = state_d == LATCH && state_q != LATCH;
    assign gap_exit  = state_q == LATCH && gap_done && bus.run;
    assign pix_last  = pix_q == PIX_W'(NUM_PIXELS - 1);
    assign hold_last = hold_q == HOLD_W'(FRAME_HOLD - 1);

    cycle_timer #(.CYCLES(LATCH_CYCLES)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(gap_start),
        .en_i   (state_q == LATCH),
        .done_o (gap_done)
    );

    // The gap after reset only primes the bus: no frame has been shown, so nothing is counted.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        first_d = first_q;
        case (state_q)
            IDLE:  state_d = LATCH;
            LATCH: if (gap_exit) begin
                first_d = 1'b0;
                if (first_q) state_d = LOAD;
                else begin
                    frame_d = frame_q + 5'd1;
                    hold_d  = hold_last ? '0 : hold_q + 1'b1;
                    state_d = hold_last ? CALC : LOAD;
                end
            end
            CALC:  if (bus.calc_ack) state_d = LOAD;
            LOAD:  state_d = XMIT;
            XMIT:  state_d = WAIT;
            WAIT:  if (bus.pixel_done) begin
                state_d = pix_last ? LATCH : LOAD;
                pix_d   = pix_last ? '0 : pix_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            pix_q   <= '0;
            frame_q <= '0;
            hold_q  <= '0;
            first_q <= 1'b1;
            load_q  <= 1'b0;
            xmit_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            first_q <= first_d;
            load_q  <= state_d == LOAD;
            xmit_q  <= state_d == XMIT;
            req_q   <= state_d == CALC;
        end

    assign bus.load_sreg      = load_q;
    assign bus.transmit_pixel = xmit_q;
    assign bus.pixel_idx      = pix_q;
    assign bus.frame_cnt      = frame_q;
    assign bus.calc_req       = req_q;

`ifdef LED_FRAME_DEBUG_EN
    logic toggle_q, perr_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            toggle_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            toggle_q <= toggle_q ^ (frame_d != frame_q);
            perr_q   <= perr_q | (bus.pixel_done && state_q != WAIT);
        end

    assign bus.frame_toggle = toggle_q;
    assign bus.proto_err    = perr_q;
`endif
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_led_frame_scheduler;
    import led_pkg::*;

    localparam int NP = 4;
    localparam int LC = 10;
    localparam int FH = 2;
    localparam int PW = pix_w(NP);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_frame_scheduler_if #(.PIX_W(PW)) bus ();

    led_frame_scheduler #(.NUM_PIXELS(NP), .LATCH_CYCLES(LC), .FRAME_HOLD(FH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: gap length in cycles, frames shown, pixel position within the frame.
    int m_gap, m_step, m_pix, m_frames;
    bit m_calc, m_first, m_started, m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 0; m_gap = -1; m_calc = 0; m_step = 0;
            m_pix = 0; m_frames = 0; m_first = 1; m_perr = 0;
        end else begin
            if (bus.pixel_done && m_step != 3) m_perr = 1;
            if (!m_started) begin
                m_started = 1;
                m_gap = 0;
            end else if (m_gap >= 0) begin
                if (m_gap + 1 >= LC && bus.run) begin
                    m_gap = -1;
                    if (m_first) begin
                        m_first = 0;
                        m_step = 1;
                    end else begin
                        m_frames++;
                        if (m_frames % FH == 0) m_calc = 1;
                        else m_step = 1;
                    end
                end else m_gap = (m_gap + 1 >= LC) ? LC : m_gap + 1;
            end else if (m_calc) begin
                if (bus.calc_ack) begin
                    m_calc = 0;
                    m_step = 1;
                end
            end else if (m_step == 1) m_step = 2;
            else if (m_step == 2) m_step = 3;
            else if (m_step == 3 && bus.pixel_done) begin
                if (m_pix == NP - 1) begin
                    m_pix = 0; m_step = 0; m_gap = 0;
                end else begin
                    m_pix++; m_step = 1;
                end
            end
        end
    end

    int cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    typedef struct {int c; int idx; int f; bit req;} ev_t;
    ev_t evq[$];
    int  req_rises, req_cyc;
    bit  wrapped, prev_req;
    int  prev_f;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("load_sreg", bus.load_sreg, m_step == 1);
            chk("transmit_pixel", bus.transmit_pixel, m_step == 2);
            chk("pixel_idx", bus.pixel_idx, m_pix);
            chk("frame_cnt", bus.frame_cnt, m_frames % 32);
            chk("calc_req", bus.calc_req, m_calc);
`ifdef LED_FRAME_DEBUG_EN
            chk("frame_toggle", bus.frame_toggle, m_frames % 2);
            chk("proto_err", bus.proto_err, m_perr);
`endif
            if (bus.load_sreg) evq.push_back('{cyc, int'(bus.pixel_idx), int'(bus.frame_cnt), bus.calc_req});
            if (bus.calc_req && !prev_req) begin
                req_rises++;
                req_cyc = cyc;
            end
            if (prev_f == 31 && bus.frame_cnt == 0) wrapped = 1;
        end
        prev_req = bus.calc_req;
        prev_f = int'(bus.frame_cnt);
    end

    // Driver / life-engine / run stimulus, all changing on the falling edge.
    bit rand_mode = 0, run_req = 1, inj_once = 0, inj_on_load = 0, run_r = 1, req_seen = 0;
    int d_cd = 0, a_cd = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_cd = 0;
            a_cd = 0;
        end
        bus.pixel_done = 1'b0;
        bus.calc_ack = 1'b0;
        if (d_cd > 0) begin
            d_cd--;
            if (d_cd == 0) bus.pixel_done = 1'b1;
        end
        if (bus.transmit_pixel) d_cd = rand_mode ? int'($urandom_range(1, 40)) : 30;
        if (inj_once) begin
            bus.pixel_done = 1'b1;
            inj_once = 0;
        end
        if (inj_on_load && bus.load_sreg) bus.pixel_done = 1'b1;
        if (rand_mode && $urandom_range(0, 19) == 0) bus.pixel_done = 1'b1;
        if (a_cd > 0) begin
            a_cd--;
            if (a_cd == 0) bus.calc_ack = 1'b1;
        end
        if (bus.calc_req && !req_seen) a_cd = 5;
        req_seen = bus.calc_req;
        if (rand_mode) bus.calc_ack = $urandom_range(0, 3) == 0;
        if (rand_mode && $urandom_range(0, 49) == 0) run_r = ~run_r;
        bus.run = rand_mode ? run_r : run_req;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_load_sreg"}, bus.load_sreg, 0);
        chk({tag, "_transmit"}, bus.transmit_pixel, 0);
        chk({tag, "_pixel_idx"}, bus.pixel_idx, 0);
        chk({tag, "_frame_cnt"}, bus.frame_cnt, 0);
        chk({tag, "_calc_req"}, bus.calc_req, 0);
`ifdef LED_FRAME_DEBUG_EN
        chk({tag, "_frame_toggle"}, bus.frame_toggle, 0);
        chk({tag, "_proto_err"}, bus.proto_err, 0);
`endif
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (evq.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (evq.size() < n) chk(tag, evq.size(), n);
    endtask

    initial begin
        int k, r0;
        bus.run = 1'b1;
        bus.pixel_done = 1'b0;
        bus.calc_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        #1 rst_n = 1'b1;
        wait_log(4, 400, "first_frame_timeout");
        for (int i = 0; i < 4 && i < evq.size(); i++) begin
            chk("load_cycle", evq[i].c, 11 + 32 * i);
            chk("load_idx", evq[i].idx, i);
        end
        k = 0;
        while (req_rises < 1 && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("calc_req_rise_cycle", req_cyc, 287);
        evq.delete();
        wait_log(1, 100, "post_calc_timeout");
        if (evq.size() > 0) begin
            chk("post_calc_load_cycle", evq[0].c, 293);
            chk("post_calc_idx", evq[0].idx, 0);
            chk("post_calc_frame_cnt", evq[0].f, 2);
            chk("post_calc_req_low", evq[0].req, 0);
        end
        run_req = 0;
        evq.delete();
        repeat (300) @(negedge clk);
        #1;
        chk("parked_loads", evq.size(), 3);
        if (evq.size() > 0) chk("parked_last_idx", evq[evq.size()-1].idx, 3);
        chk("parked_load_sreg", bus.load_sreg, 0);
        inj_once = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("inject_latch_loads", evq.size(), 3);
        chk("inject_latch_idx", bus.pixel_idx, 0);
`ifdef LED_FRAME_DEBUG_EN
        chk("inject_latch_proto_err", bus.proto_err, 1);
`endif
        evq.delete();
        r0 = cyc;
        run_req = 1;
        inj_on_load = 1;
        wait_log(1, 20, "resume_timeout");
        if (evq.size() > 0) begin
            chk("resume_load_cycle", evq[0].c, r0 + 2);
            chk("resume_frame_cnt", evq[0].f, 3);
        end
        @(negedge clk);
        #1;
        inj_on_load = 0;
        chk("inject_load_idx", bus.pixel_idx, 0);
        k = 0;
        while (!(evq.size() > 0 && evq[evq.size()-1].idx == 2) && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(negedge clk);
        evq.delete();
        req_rises = 0;
        wrapped = 0;
        #2 rst_n = 1'b1;
        wait_log(1, 100, "post_reset_timeout");
        if (evq.size() > 0) begin
            chk("post_reset_load_cycle", evq[0].c, 11);
            chk("post_reset_idx", evq[0].idx, 0);
        end
        k = 0;
        while (!wrapped && k < 8000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wrap_seen", wrapped, 1);
        chk("calc_req_count_32_frames", req_rises, 16);
        chk("frame_cnt_after_wrap", bus.frame_cnt, 0);
        rand_mode = 1;
        repeat (20000) @(negedge clk);
        rand_mode = 0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
